// File: rtl/beta_backward_razor.sv
// Max-log MAP backward (beta) recursion: a LIFO holds the window of branch metrics and is replayed in reverse.
// Latency: first beta 1 cycle after window close, then 1/cycle (BETA_RAZOR_EN: 2 cycles, then 1 per 2 cycles).
// Backpressure: in_ready only while filling; out_ready low holds beta_out and stalls the recursion.
module beta_backward_razor #(
    parameter int N        = 5,
    parameter int M        = 6,
    parameter int RazorBit = 1,
    parameter int DEPTH    = 16
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [N-1:0]          ba2,
    input  logic [M:0]            ba1ba3,
    input  logic [M:0]            ba1ba2ba3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [7:1][M-1:0]     beta_out,
    output logic                  Error_current_Beta,
    input  logic                  err_inject
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {FILL, RUN, CHECK, DONE} state_t;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [7:1][M-1:0]   beta_src;
    logic [7:1][M-1:0]   d;
    logic [7:1][M-1:0]   commit_val;
    logic                can_commit;
    logic                commit_go;

    logic [N-1:0]        st_g2   [DEPTH];
    logic [M:0]          st_g13  [DEPTH];
    logic [M:0]          st_g123 [DEPTH];
    logic [IW-1:0]       rd_idx;

    assign in_ready   = (state == FILL);
    assign rd_idx     = IW'(ptr - PW'(1));
    assign can_commit = !out_valid || out_ready;

    always_ff @(posedge Clock) begin
        if (state == FILL && in_valid) begin
            st_g2[IW'(ptr)]   <= ba2;
            st_g13[IW'(ptr)]  <= ba1ba3;
            st_g123[IW'(ptr)] <= ba1ba2ba3;
        end
    end

    function automatic logic signed [M+1:0] smax(input logic signed [M+1:0] a, input logic signed [M+1:0] c);
        return (a > c) ? a : c;
    endfunction

    logic signed [M+1:0] b [8];
    logic signed [M+1:0] n [8];
    logic signed [M+1:0] g2x, g13x, g123x;
    logic signed [M+2:0] dd [1:7];

    always_comb begin
        d     = '0;
        b[0]  = '0;
        g2x   = {{(M+2-N){st_g2[rd_idx][N-1]}}, st_g2[rd_idx]};
        g13x  = {st_g13[rd_idx][M], st_g13[rd_idx]};
        g123x = {st_g123[rd_idx][M], st_g123[rd_idx]};
        for (int s = 1; s < 8; s++) begin
            b[s] = {{2{beta_src[s][M-1]}}, beta_src[s]};
        end
        n[0] = smax(b[0],         b[4] + g123x);
        n[1] = smax(b[0] + g123x, b[4]);
        n[2] = smax(b[1] + g13x,  b[5] + g2x);
        n[3] = smax(b[1] + g2x,   b[5] + g13x);
        n[4] = smax(b[2] + g2x,   b[6] + g13x);
        n[5] = smax(b[2] + g13x,  b[6] + g2x);
        n[6] = smax(b[3] + g123x, b[7]);
        n[7] = smax(b[3],         b[7] + g123x);
        // Normalize against state 0, then clamp into the M-bit signed range.
        for (int s = 1; s < 8; s++) begin
            dd[s] = {n[s][M+1], n[s]} - {n[0][M+1], n[0]};
            if (dd[s][M+2] == 1'b0 && dd[s][M+1:M-1] != 3'b000)
                d[s] = {1'b0, {(M-1){1'b1}}};
            else if (dd[s][M+2] == 1'b1 && dd[s][M+1:M-1] != 3'b111)
                d[s] = {1'b1, {(M-1){1'b0}}};
            else
                d[s] = dd[s][M-1:0];
        end
    end

`ifdef BETA_RAZOR_EN
    localparam int     RB        = M - RazorBit;
    localparam state_t COMMIT_ST = CHECK;

    logic [7:1][M-1:0] beta_dff;
    logic [7:1]        shadow;
    logic [7:1]        d_bit;
    logic [7:1]        dff_bit;
    logic              err;

    always_comb begin
        for (int s = 1; s < 8; s++) begin
            d_bit[s]   = d[s][RB];
            dff_bit[s] = beta_dff[s][RB];
        end
    end

    // Shadow copy of the monitored bit, captured late in the CHECK cycle while Clock is high.
    always_latch begin
        if (!nReset)
            shadow <= '0;
        else if (Clock)
            shadow <= d_bit;
    end

    assign err = (state == CHECK) && ((|(shadow ^ dff_bit)) || err_inject);

    always_comb begin
        for (int s = 1; s < 8; s++) begin
            commit_val[s] = beta_dff[s] ^ ({{(M-1){1'b0}}, err} << RB);
        end
    end

    assign Error_current_Beta = err;
`else
    localparam state_t COMMIT_ST = RUN;
    logic unused_err_inject;

    assign unused_err_inject  = err_inject;
    assign commit_val         = d;
    assign Error_current_Beta = 1'b0;
`endif

    assign commit_go = can_commit && (state == COMMIT_ST);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state     <= FILL;
            ptr       <= '0;
            beta_src  <= '0;
            beta_out  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef BETA_RAZOR_EN
            beta_dff  <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid) begin
                        ptr <= ptr + PW'(1);
                        if (in_last || ptr == PW'(DEPTH - 1))
                            state <= RUN;
                    end
                end
                RUN: begin
`ifdef BETA_RAZOR_EN
                    beta_dff <= d;
                    state    <= CHECK;
`endif
                end
                CHECK: ;
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_last <= 1'b0;
                        beta_src <= '0;
                        state    <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
            if (commit_go) begin
                beta_src  <= commit_val;
                beta_out  <= commit_val;
                out_valid <= 1'b1;
                ptr       <= ptr - PW'(1);
                out_last  <= (ptr == PW'(1));
                state     <= (ptr == PW'(1)) ? DONE : RUN;
            end
        end
    end
endmodule

// File: tb/tb_beta_backward_razor.sv
// Directed bench for beta_backward_razor: hand-computed single steps, windowed reverse replay, stalls, reset.
module tb_beta_backward_razor;
    localparam int N     = 5;
    localparam int M     = 6;
    localparam int W1    = M + 1;
    localparam int DEPTH = 16;
`ifdef BETA_RAZOR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              Clock = 1'b0;
    logic              nReset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [N-1:0]      ba2 = '0;
    logic [M:0]        ba1ba3 = '0;
    logic [M:0]        ba1ba2ba3 = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic [7:1][M-1:0] beta_out;
    logic              Error_current_Beta;
    logic              err_inject = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    beta_backward_razor #(.N(N), .M(M), .RazorBit(1), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .nReset(nReset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .ba2(ba2), .ba1ba3(ba1ba3), .ba1ba2ba3(ba1ba2ba3),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .beta_out(beta_out), .Error_current_Beta(Error_current_Beta), .err_inject(err_inject)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mx(input int a, input int c);
        return (a > c) ? a : c;
    endfunction

    function automatic logic [7:1][M-1:0] mk(input int v1, v2, v3, v4, v5, v6, v7);
        logic [7:1][M-1:0] r;
        r[1] = M'(v1); r[2] = M'(v2); r[3] = M'(v3); r[4] = M'(v4);
        r[5] = M'(v5); r[6] = M'(v6); r[7] = M'(v7);
        return r;
    endfunction

    // Reference recursion step in plain integer arithmetic.
    function automatic logic [7:1][M-1:0] mstep(input logic [7:1][M-1:0] bv, input int g2, g13, g123);
        int b[8];
        int n[8];
        int dv;
        logic [7:1][M-1:0] r;
        b[0] = 0;
        for (int s = 1; s < 8; s++) b[s] = int'($signed(bv[s]));
        n[0] = mx(b[0], b[4] + g123);   n[1] = mx(b[0] + g123, b[4]);
        n[2] = mx(b[1] + g13, b[5] + g2); n[3] = mx(b[1] + g2, b[5] + g13);
        n[4] = mx(b[2] + g2, b[6] + g13); n[5] = mx(b[2] + g13, b[6] + g2);
        n[6] = mx(b[3] + g123, b[7]);   n[7] = mx(b[3], b[7] + g123);
        for (int s = 1; s < 8; s++) begin
            dv = n[s] - n[0];
            if (dv > 31) dv = 31;
            if (dv < -32) dv = -32;
            r[s] = M'(dv);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input int g2, g13, g123, input logic last);
        in_valid  = 1'b1;
        ba2       = N'(g2);
        ba1ba3    = W1'(g13);
        ba1ba2ba3 = W1'(g123);
        in_last   = last;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int waited);
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    int t2 [DEPTH];
    int t13 [DEPTH];
    int t123 [DEPTH];
    logic [7:1][M-1:0] ev [DEPTH];
    logic [7:1][M-1:0] bm;
    int w;

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_beta", beta_out, '0);
        chk("rst_err", Error_current_Beta, 1'b0);
        nReset = 1'b1;
        tick();

        // One step, all metrics zero
        push(0, 0, 0, 1'b1);
        chk("zero_in_ready_run", in_ready, 1'b0);
        repeat (LAT) tick();
        chk("zero_valid", out_valid, 1'b1);
        chk("zero_last", out_last, 1'b1);
        chk("zero_beta", beta_out, '0);
        tick();
        chk("zero_done_valid", out_valid, 1'b0);
        chk("zero_back_fill", in_ready, 1'b1);

        // One step, ba1ba2ba3 = +5
        push(0, 0, 5, 1'b1);
        repeat (LAT) tick();
        chk("g123_valid", out_valid, 1'b1);
        chk("g123_beta", beta_out, mk(0, -5, -5, -5, -5, 0, 0));
        tick();

        // One step, ba1ba3 = +63 saturates states 2..5
`ifndef BETA_RAZOR_EN
        err_inject = 1'b1;
`endif
        push(0, 63, 0, 1'b1);
        repeat (LAT) tick();
        chk("sat_beta", beta_out, mk(0, 31, 31, 31, 31, 0, 0));
        chk("sat_last", out_last, 1'b1);
`ifndef BETA_RAZOR_EN
        chk("err_ignored", Error_current_Beta, 1'b0);
        err_inject = 1'b0;
`endif
        tick();

        // Four-step window with a 3-cycle stall on the first beat
        t2[0] = 3;   t13[0] = -7; t123[0] = 10;
        t2[1] = -4;  t13[1] = 12; t123[1] = -2;
        t2[2] = 9;   t13[2] = 5;  t123[2] = -20;
        t2[3] = -15; t13[3] = 30; t123[3] = 25;
        bm = '0;
        for (int k = 0; k < 4; k++) begin
            bm = mstep(bm, t2[3-k], t13[3-k], t123[3-k]);
            ev[k] = bm;
        end
        for (int k = 0; k < 4; k++) push(t2[k], t13[k], t123[k], k == 3);
        out_ready = 1'b0;
        repeat (LAT) tick();
        chk("win4_first_valid", out_valid, 1'b1);
        chk("win4_first_beta", beta_out, mk(0, 5, 5, 5, 5, 0, 0));
        chk("win4_first_last", out_last, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("win4_stall_valid", out_valid, 1'b1);
            chk("win4_stall_beta", beta_out, mk(0, 5, 5, 5, 5, 0, 0));
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            wait_valid("win4_wait", w);
            chk("win4_beta", beta_out, ev[k]);
            chk("win4_last", out_last, k == 3);
        end
        tick();
        chk("win4_end_valid", out_valid, 1'b0);

        // Sixteen pushes without in_last: forced close; in_valid kept high is ignored
        for (int i = 0; i < DEPTH; i++) begin
            t2[i]   = ((i * 7) % 32) - 16;
            t13[i]  = ((i * 29) % 128) - 64;
            t123[i] = ((i * 53) % 128) - 64;
        end
        bm = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bm = mstep(bm, t2[DEPTH-1-k], t13[DEPTH-1-k], t123[DEPTH-1-k]);
            ev[k] = bm;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_ready_before_last", in_ready, 1'b1);
            push(t2[i], t13[i], t123[i], 1'b0);
        end
        chk("full_closed", in_ready, 1'b0);
        in_valid = 1'b1;
        ba2 = 5'd7; ba1ba3 = 7'd9; ba1ba2ba3 = 7'd11;
        wait_valid("full_wait_first", w);
        chk("full_first_latency", w, LAT);
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) begin
                tick();
                wait_valid("full_wait", w);
                chk("full_throughput", w, LAT - 1);
            end
            chk("full_beta", beta_out, ev[k]);
            chk("full_last", out_last, k == DEPTH - 1);
            chk("full_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        tick();
        chk("full_back_fill", in_ready, 1'b1);
        chk("full_end_valid", out_valid, 1'b0);

        // Reset in the middle of a window discards it
        for (int k = 0; k < 4; k++) push(t2[k], t13[k], t123[k], k == 3);
        wait_valid("mid_wait", w);
        tick();
        nReset = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_fill", in_ready, 1'b1);
        nReset = 1'b1;
        push(0, 0, 5, 1'b1);
        repeat (LAT) tick();
        chk("mid_after_beta", beta_out, mk(0, -5, -5, -5, -5, 0, 0));
        chk("mid_after_last", out_last, 1'b1);
        tick();

`ifdef BETA_RAZOR_EN
        // Injected error on step 1 flips bit 5 of every state and feeds back
        push(1, 2, 3, 1'b0);
        push(0, 0, 5, 1'b1);
        tick();
        err_inject = 1'b1;
        #1;
        chk("rz_err_flag", Error_current_Beta, 1'b1);
        chk("rz_no_valid_yet", out_valid, 1'b0);
        tick();
        err_inject = 1'b0;
        bm = mk(-32, 27, 27, 27, 27, -32, -32);
        chk("rz_flipped_beta", beta_out, bm);
        chk("rz_err_clear", Error_current_Beta, 1'b0);
        tick();
        wait_valid("rz_wait", w);
        chk("rz_step2_rate", w, 1);
        chk("rz_step2_beta", beta_out, mstep(bm, 1, 2, 3));
        chk("rz_step2_last", out_last, 1'b1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/beta_backward_razor.md
Name: beta_backward_razor

Overview:
- Backward (beta) recursion engine for the 8-state max-log MAP trellis; the counterpart of the forward alpha pipe stage.
- Accepts one window of per-step branch-metric triples in forward order and buffers them in a LIFO.
- Replays the window in reverse, emitting one normalized, saturated beta vector (states 1..7; state 0 is 0 after normalization) per step through a valid/ready handshake.
- Optional Razor-style shadow check with in-place correction of the monitored bit.

Parameters:
- N, 5: width of signed ba2.
- M, 6: width of signed beta metrics; ba1ba3 and ba1ba2ba3 are M+1 bits.
- RazorBit, 1: monitored bit is M-RazorBit; must be 1 or 2.
- DEPTH, 16: LIFO depth, i.e. maximum window length (power of 2, >=2).

Ports:
- Clock  in  1  single clock, rising edge.
- nReset  in  1  synchronous active-low reset, sampled on rising Clock.
- in_valid  in  1  branch-metric triple valid.
- in_ready  out  1  high only in FILL.
- in_last  in  1  marks the last step of the window.
- ba2  in  N  signed.
- ba1ba3  in  M+1  signed.
- ba1ba2ba3  in  M+1  signed.
- out_valid  out  1  beta_out valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final beta of the window.
- beta_out  out  7*M  packed [7:1][M-1:0], signed.
- Error_current_Beta  out  1  shadow mismatch flag; constant 0 without BETA_RAZOR_EN.
- err_inject  in  1  forces a shadow mismatch; used only with BETA_RAZOR_EN, ignored otherwise.

Behaviour:
- Reset (nReset=0 at a rising edge):
  - state=FILL, ptr=0.
  - beta_src, beta_dff, beta_out all 0.
  - out_valid=0, out_last=0, shadow latch=0, Error_current_Beta=0.
  - Reset mid-window discards all LIFO contents.
- FILL:
  - in_ready=1.
  - Each in_valid cycle pushes {ba2, ba1ba3, ba1ba2ba3} to stack[ptr] and increments ptr.
  - Go to RUN when in_last is accepted, or when the DEPTH-th push is accepted without in_last (forced window close).
  - in_valid during RUN/DONE is ignored; in_ready=0.
- Step datapath (combinational):
  - Inputs: b = beta_src with b0 = 0; g = stack[ptr-1], with g2=ba2, g13=ba1ba3, g123=ba1ba2ba3.
  - Sums are M+2 bits, sign-extended.
  - n0=max(b0, b4+g123); n1=max(b0+g123, b4)
  - n2=max(b1+g13, b5+g2); n3=max(b1+g2, b5+g13)
  - n4=max(b2+g2, b6+g13); n5=max(b2+g13, b6+g2)
  - n6=max(b3+g123, b7); n7=max(b3, b7+g123)
  - Normalize: d_s = n_s - n0 (M+3 bits), s=1..7.
  - Saturate each d_s to M-bit signed, range [-2^(M-1), 2^(M-1)-1].
  - Ties in max are irrelevant: either operand gives the same value.
- Commit (only when !out_valid || out_ready):
  - beta_src <= committed value; beta_out <= committed value.
  - out_valid <= 1; ptr <= ptr-1.
  - out_last <= (ptr==1).
  - When ptr becomes 0, go to DONE.
- Output handshake:
  - If out_valid && out_ready and no new commit in that cycle, out_valid <= 0.
  - beta_out is stable while out_valid && !out_ready.
- DONE: when out_valid && out_ready on the out_last beat: out_valid <= 0, out_last <= 0, beta_src <= 0, go to FILL.
- Without BETA_RAZOR_EN:
  - RUN commits d directly.
  - Every cycle is a commit opportunity, so throughput is 1 beta per cycle.
  - First out_valid is 1 cycle after entering RUN.
- Output order: reverse of push order. The first output uses the last-pushed triple.

Optional Feature:
- Macro: BETA_RAZOR_EN.
- RUN alternates COMP and CHECK cycles. ptr and beta_src are held across both, so datapath sources are stable.
- COMP: beta_dff <= d.
- CHECK:
  - Shadow latch (transparent while Clock high, reset 0) samples bit M-RazorBit of d for states 1..7.
  - Error_current_Beta = OR over s of (latch_s XOR beta_dff[s][M-RazorBit]) OR err_inject.
  - TrueQ[s] = beta_dff[s] with bit M-RazorBit XORed with the error; for RazorBit=2 the MSB passes through unchanged.
  - The commit (same stall rule as above) uses TrueQ; otherwise stay in CHECK.
- Throughput: 1 beta per 2 cycles; first out_valid 2 cycles after entering RUN.
- Without the macro: no latch, no COMP/CHECK split, and err_inject is unused.

Test Plan:
- One-step window, all metrics 0, in_last=1 -> beta_out all 0, out_valid and out_last high 1 cycle after RUN, then back to FILL with in_ready=1.
- One step, ba1ba2ba3=+5, ba2=ba1ba3=0 -> beta_out[1..7] = {0,-5,-5,-5,-5,0,0}.
- One step, ba1ba3=+63, ba2=0, ba1ba2ba3=0 -> beta2..5 = +31 (saturated), beta1=beta6=beta7=0.
- 4-step window with distinct triples, out_ready low for 3 cycles after the first out_valid -> beta_out held, ptr unchanged; outputs match the golden model in reverse order, out_last on the 4th.
- 16 pushes without in_last -> forced close, in_ready=0 through RUN/DONE, 16 outputs; nReset=0 mid-RUN -> out_valid=0, ptr=0, FILL next cycle.
- BETA_RAZOR_EN, err_inject=1 in CHECK of step 1 (M=6, RazorBit=1) -> Error_current_Beta=1, bit 5 of all seven beta_out flipped vs model, flipped value fed back to step 2; outputs one per 2 cycles.
